// File: rtl/display_scan_controller_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns {g,f,e,d,c,b,a} and the digit count of the display.
package display_scan_controller_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIGIT_W = 2;

  typedef logic [DIGIT_W-1:0] digit_idx_t;
  typedef logic [6:0]         seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seven_seg
  import display_scan_controller_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller: prescaled digit stepping, frame-
// synchronous double-buffered value, and optional leading-zero blanking.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*DIGITS-1:0]     i_value,
  input  logic [DIGITS-1:0]       i_dp_mask,
  input  logic                    i_blank_lz,
  output logic [DIGIT_W-1:0]      o_display_choice,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  logic [CNT_W-1:0]      r_presc;
  digit_idx_t            r_choice;
  logic [4*DIGITS-1:0]   r_active;
  logic [DIGITS-1:0]     r_active_dp;
  logic [4*DIGITS-1:0]   r_pend;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_valid;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_xfer;
  digit_idx_t            w_next_choice;
  logic [4*DIGITS-1:0]   w_next_active;
  logic [DIGITS-1:0]     w_next_dp;
  logic [3:0]            w_nibble;
  logic [DIGITS-1:0]     w_lz;
  logic                  w_blank;
  logic [6:0]            w_dec_seg;

  assign w_tick        = (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_frame_end   = w_tick && (r_choice == digit_idx_t'(DIGITS - 1));
  assign w_xfer        = w_frame_end && r_pend_valid;
  assign w_next_choice = r_choice + digit_idx_t'(1);

  // Segments are computed for the digit about to be shown, from the value it
  // will be shown with, so index and segments change on the same edge.
  assign w_next_active = w_xfer ? r_pend    : r_active;
  assign w_next_dp     = w_xfer ? r_pend_dp : r_active_dp;

  always_comb begin
    w_nibble = 4'h0;
    unique case (w_next_choice)
      2'd0: w_nibble = w_next_active[3:0];
      2'd1: w_nibble = w_next_active[7:4];
      2'd2: w_nibble = w_next_active[11:8];
      2'd3: w_nibble = w_next_active[15:12];
      default: w_nibble = 4'h0;
    endcase
  end

  // w_lz[n]: every nibble from the top digit down to n is zero.
  always_comb begin
    w_lz    = '0;
    w_lz[3] = (w_next_active[15:12] == 4'h0);
    w_lz[2] = w_lz[3] && (w_next_active[11:8] == 4'h0);
    w_lz[1] = w_lz[2] && (w_next_active[7:4] == 4'h0);
    w_lz[0] = 1'b0;
  end

  assign w_blank = i_blank_lz && w_lz[w_next_choice];

  hex_to_seven_seg u_hex_to_seven_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc      <= '0;
      r_choice     <= '0;
      r_active     <= '0;
      r_active_dp  <= '0;
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_seg        <= SEG_0;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + CNT_W'(1);
      r_frame_done <= w_frame_end;

      if (w_tick) begin
        r_choice <= w_next_choice;
        r_seg    <= w_blank ? SEG_BLANK : w_dec_seg;
        r_dp     <= ~w_next_dp[w_next_choice];
      end

      if (w_xfer) begin
        r_active    <= r_pend;
        r_active_dp <= r_pend_dp;
      end

      // A load coincident with a transfer refills pending and keeps it valid.
      if (i_load) begin
        r_pend       <= i_value;
        r_pend_dp    <= i_dp_mask;
        r_pend_valid <= 1'b1;
      end else if (w_xfer) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign o_display_choice = r_choice;
  assign o_seg            = r_seg;
  assign o_dp             = r_dp;
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with REFRESH_DIV = 4.
module tb_display_scan_controller;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [1:0]  display_choice;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp;
  int n_mis;
  int k;

  display_scan_controller #(
    .REFRESH_DIV (4),
    .CNT_W       (3)
  ) u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_load           (load),
    .i_value          (value),
    .i_dp_mask        (dp_mask),
    .i_blank_lz       (blank_lz),
    .o_display_choice (display_choice),
    .o_seg            (seg),
    .o_dp             (dp),
    .o_frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s (k=%0d): got %h, want %h", tag, k, obs, expv);
    end
  endtask

  // Advance one clock; sampling happens on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) step();
  endtask

  task automatic slot_chk(input string tag, input logic [1:0] idx, input logic [6:0] s,
                          input logic d);
    check({tag, ".idx"}, 16'(display_choice), 16'(idx));
    check({tag, ".seg"}, 16'(seg), 16'(s));
    check({tag, ".dp"},  16'(dp), 16'(d));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    value   = v;
    dp_mask = m;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    k        = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_mask  = 4'h0;
    blank_lz = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;

    // 1: reset state and one idle frame
    for (int i = 0; i < 16; i++) begin
      slot_chk("idle", 2'(i / 4), 7'b1000000, 1'b1);
      check("idle.fd", 16'(frame_done), 16'h0);
      step();
    end
    check("fd.pulse", 16'(frame_done), 16'h1);
    check("fd.idx0",  16'(display_choice), 16'h0);
    step();
    check("fd.clear", 16'(frame_done), 16'h0);

    // 2: mid-frame load is held until the frame boundary
    go_to(21);
    do_load(16'h1A2F, 4'b0010);
    slot_chk("hold1", 2'd1, 7'b1000000, 1'b1);
    go_to(31);
    slot_chk("hold3", 2'd3, 7'b1000000, 1'b1);
    go_to(32); slot_chk("1A2F.d0", 2'd0, 7'b0001110, 1'b1);
    go_to(36); slot_chk("1A2F.d1", 2'd1, 7'b0100100, 1'b0);
    go_to(40); slot_chk("1A2F.d2", 2'd2, 7'b0001000, 1'b1);
    go_to(44); slot_chk("1A2F.d3", 2'd3, 7'b1111001, 1'b1);

    // 3: leading-zero blanking, dp still shown on a blanked digit
    go_to(45);
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0100);
    go_to(48); slot_chk("lz.d0", 2'd0, 7'b0010010, 1'b1);
    go_to(52); slot_chk("lz.d1", 2'd1, 7'b1111111, 1'b1);
    go_to(56); slot_chk("lz.d2", 2'd2, 7'b1111111, 1'b0);
    go_to(60); slot_chk("lz.d3", 2'd3, 7'b1111111, 1'b1);
    go_to(61);
    blank_lz = 1'b0;
    go_to(64); slot_chk("nolz.d0", 2'd0, 7'b0010010, 1'b1);
    go_to(68); slot_chk("nolz.d1", 2'd1, 7'b1000000, 1'b1);
    go_to(72); slot_chk("nolz.d2", 2'd2, 7'b1000000, 1'b0);
    go_to(76); slot_chk("nolz.d3", 2'd3, 7'b1000000, 1'b1);

    // 4: last load in a frame wins
    go_to(77);
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    go_to(80); slot_chk("2222.d0", 2'd0, 7'b0100100, 1'b1);
    go_to(84); slot_chk("2222.d1", 2'd1, 7'b0100100, 1'b1);
    go_to(88); slot_chk("2222.d2", 2'd2, 7'b0100100, 1'b1);
    go_to(92); slot_chk("2222.d3", 2'd3, 7'b0100100, 1'b1);

    // 4b: load coincident with the frame-end tick lands one frame later
    go_to(90);
    do_load(16'h4444, 4'h0);
    go_to(95);
    do_load(16'h3333, 4'h0);
    check("coinc.fd", 16'(frame_done), 16'h1);
    slot_chk("4444.d0", 2'd0, 7'b0011001, 1'b1);
    go_to(108); slot_chk("4444.d3", 2'd3, 7'b0011001, 1'b1);
    go_to(112); slot_chk("3333.d0", 2'd0, 7'b0110000, 1'b1);
    check("3333.fd", 16'(frame_done), 16'h1);
    go_to(116); slot_chk("3333.d1", 2'd1, 7'b0110000, 1'b1);

    // 5: reset mid-frame with a pending load discards everything
    go_to(117);
    do_load(16'h5555, 4'hF);
    go_to(121);
    slot_chk("prerst", 2'd2, 7'b0110000, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    slot_chk("rst", 2'd0, 7'b1000000, 1'b1);
    check("rst.fd", 16'(frame_done), 16'h0);
    k = 0;
    go_to(16); slot_chk("postrst.d0", 2'd0, 7'b1000000, 1'b1);
    go_to(20); slot_chk("postrst.d1", 2'd1, 7'b1000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexing stage that drives the 4-digit seven-segment display. It sits directly upstream of the anode decoder: it produces the 2-bit display_choice digit index plus the active-low segment and decimal-point lines for that digit. It holds a tear-free double-buffered copy of a 16-bit hex value, steps through the digits at a programmable refresh rate, and optionally blanks leading zeros.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2. Use 4 in simulation.
CNT_W, 17, prescaler width; must satisfy 2**CNT_W >= REFRESH_DIV.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
load  input  1  one-cycle strobe; capture value and dp_mask into the pending buffer
value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp_mask  input  4  per-digit decimal point, 1 = lit; bit k is digit k
blank_lz  input  1  1 = blank leading zero digits (level, sampled live)
display_choice  output  2  current digit index; feeds the anode decoder
seg  output  7  active-low segments {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point
frame_done  output  1  one-cycle pulse when digit 3's slot ends

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. All state is in the clk domain.
- Reset values:
  - prescaler = 0, display_choice = 0
  - active value and active dp = 0; pending buffer = 0; pending_valid = 0
  - seg = 7'b1000000 (shows "0"), dp = 1, frame_done = 0
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - tick is asserted in the cycle the count equals REFRESH_DIV-1.
- Digit stepping:
  - On tick, display_choice increments modulo 4 (3 -> 0).
  - seg and dp are registered and update in the same edge as display_choice, so they always describe the digit being shown. There is no extra latency between index and segments.
  - Each digit is shown for exactly REFRESH_DIV cycles; a full frame is 4*REFRESH_DIV cycles.
- Double buffer:
  - load copies value and dp_mask into the pending buffer and sets pending_valid.
  - On tick while display_choice == 3 (end of frame), if pending_valid is set: copy pending into active and clear pending_valid.
  - frame_done pulses on that same edge, whether or not a transfer happens.
  - load in the same cycle as a transfer: the transfer uses the old pending contents; the new data lands in pending and pending_valid stays 1. The new value appears one frame later.
  - Multiple loads within one frame: the last one wins.
- Segment data for next digit n:
  - The nibble is active[4n+3:4n], encoded as hex 0-F in active-low form. Examples: 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
  - dp = ~active_dp[n].
- Leading-zero blanking:
  - Digit n (n = 1..3) is blank when blank_lz = 1 and every active nibble from 3 down to n is 0.
  - Digit 0 is never blanked.
  - A blank digit drives seg = 7'b1111111. dp still follows dp_mask.
- Reset mid-frame: everything returns to its reset values on the next edge, and the pending load is discarded.
- display_choice always cycles, even if the value never changes.

Decomposition:
- Shared package: the segment encoding constants SEG_0..SEG_F and SEG_BLANK = 7'b1111111, plus DIGITS = 4.
- One sub-module, hex_to_seven_seg: a combinational 4-bit nibble to 7-bit active-low decoder. It is reusable by other display blocks.
- The controller holds the prescaler, the digit counter, the double buffer and the blanking logic.

Test Plan (REFRESH_DIV = 4):
1. Reset, then run 16 cycles.
   -> display_choice goes 0,1,2,3 with each value held 4 cycles; seg = 1000000 in every slot; frame_done pulses once at the 3->0 edge.
2. load value = 16'h1A2F, dp_mask = 4'b0010, blank_lz = 0, mid-frame.
   -> Outputs are unchanged until the frame end.
   -> Next frame shows digit 0 seg 0001110 (F), digit 1 seg 0100100 (2) with dp = 0, digit 2 seg 0001000 (A), digit 3 seg 1111001 (1).
3. value = 16'h0005, blank_lz = 1.
   -> Digits 3, 2, 1 show seg 1111111; digit 0 shows 0010010.
   -> Set blank_lz = 0: digits 1-3 show 1000000 from the next slot onward.
4. load 16'h1111 and then load 16'h2222 in the same frame.
   -> Next frame shows only 2222 (0100100 on all digits).
   -> A load coincident with the frame-end tick appears one frame later.
5. Assert rst for 1 cycle while display_choice = 2 and pending_valid = 1.
   -> Next edge: display_choice = 0, seg = 1000000, dp = 1, and the pending value is never shown.
